midi_voice_dds: RTL and testbench
=================================

Name: midi_voice_dds

Overview:
Single monophonic MIDI voice that plays the accumulator increments produced by the note-number-to-increment table. It accepts note-on/note-off events from the MIDI parser, drives the note number to the table, and latches the returned 24-bit increment. It then runs a 24-bit DDS phase accumulator on a sample strobe and emits a signed, velocity-scaled waveform with a linear release, feeding the PWM/DAC stage.

Parameters:
ACC_W, 24, phase accumulator and increment width; must match the table output width.
RELEASE_DIV, 64, number of sample strobes per one-step amplitude decrement during release; minimum 1.

Ports:
i_clk  input  1  system clock; the only clock.
i_res_n  input  1  asynchronous active-low reset.
i_smp_en  input  1  one-cycle sample strobe; DDS and envelope advance only on it.
i_ev_valid  input  1  event valid.
o_ev_ready  output  1  event ready; an event transfers when valid and ready are both high.
i_ev_on  input  1  1 = note-on, 0 = note-off.
i_ev_note  input  7  MIDI note number.
i_ev_vel  input  7  MIDI velocity.
o_tbl_note  output  7  note number driven to the increment table (registered).
i_tbl_val  input  ACC_W  combinational increment returned by the table for o_tbl_note.
o_wave  output  8  signed two's-complement sample.
o_active  output  1  high in LOOKUP, PLAY and RELEASE.

Behaviour:
- Reset values: state=IDLE; phase=0; inc=0; amp=0; cur_note=0; rel_cnt=0; o_tbl_note=0; o_wave=0; o_active=0; o_ev_ready=1.
- States and ready: IDLE, LOOKUP, PLAY, RELEASE. o_ev_ready is 1 in IDLE, PLAY and RELEASE, and 0 in LOOKUP.
- Note-on with vel≠0, accepted in any ready state:
  - cur_note, o_tbl_note <= i_ev_note; amp <= i_ev_vel; rel_cnt <= 0.
  - Next state is LOOKUP.
  - phase <= 0 only when coming from IDLE. A retrigger from PLAY or RELEASE keeps phase continuous.
- Note-on with vel=0 is treated exactly as note-off for i_ev_note.
- Note-off:
  - In PLAY with i_ev_note == cur_note: go to RELEASE, rel_cnt <= 0.
  - Otherwise (wrong note, IDLE, or already RELEASE): accepted and ignored.
- LOOKUP takes exactly one cycle. inc <= i_tbl_val, then go to PLAY. The event-to-PLAY latency is 2 clocks.
- Phase: on i_smp_en in PLAY or RELEASE, phase <= phase + inc, modulo 2^ACC_W (natural wrap, no saturation). The phase does not advance in IDLE or LOOKUP.
- o_wave is registered and updates only on i_smp_en:
  - In PLAY or RELEASE it is computed from the pre-update phase.
  - Square: phase[ACC_W-1]==0 gives +amp, otherwise −amp (8-bit signed; amp ≤127, so no overflow).
  - In IDLE, o_wave <= 0 on the next strobe.
  - In LOOKUP, o_wave holds its value.
- Release, on each i_smp_en in RELEASE:
  - If rel_cnt == RELEASE_DIV−1: rel_cnt <= 0 and amp <= amp−1.
  - Otherwise rel_cnt increments.
  - When amp reaches 0 (including entering RELEASE with amp already 0), go to IDLE on that strobe. o_active falls the same cycle the state becomes IDLE.
- Simultaneous events: an event arriving in the same cycle as i_smp_en is processed first for the state change. The strobe still applies phase/wave/envelope using the pre-event registers.
- An asynchronous reset in any state immediately forces all reset values. An event in flight is lost.

Optional Feature:
MIDI_VOICE_SAW_EN
- Defined: the waveform is sawtooth. o_wave = (signed(phase[ACC_W-1:ACC_W-8]) × amp) >>> 7, arithmetic shift, truncated to 8 bits.
- Undefined: square wave as above; no multiplier is synthesized.
- All other behaviour is identical.

Decomposition:
- Shared package midi_pkg:
  - state encoding constants: IDLE=2'd0, LOOKUP=2'd1, PLAY=2'd2, RELEASE=2'd3;
  - ACC_W default;
  - MIDI constant NOTE_W=7.
- One natural sub-module: midi_voice_env, holding the amp/rel_cnt release counter with load, start and done.
- The DDS and FSM stay in the top module. The increment table stays external.

Test Plan:
- Reset: hold i_res_n=0 mid-PLAY → o_wave=0, o_active=0, o_ev_ready=1, o_tbl_note=0 asynchronously.
- Note-on 69 vel 127, table returns 24'h00CD0E:
  - o_tbl_note=69 one clock later, o_ev_ready=0 for one cycle, inc=0x00CD0E;
  - with a strobe every cycle, o_wave=+127 until the strobe after phase crosses 0x800000 (160 strobes), then −127.
- Wrap-around: inc=24'h16D5DC (note 127) → phase wraps modulo 2^24 without stall; square period is about 11.2 strobes.
- Note-off for note 60 while playing 69 → ignored, still PLAY. Note-off 69 with amp=2, RELEASE_DIV=4 → amp 1 after 4 strobes, 0 after 8, then IDLE with o_active=0.
- Note-on 72 vel 0 while playing 72 → enters RELEASE. Note-on 64 vel 50 during RELEASE → LOOKUP, amp=50, phase not reset.
- Event valid coincident with i_smp_en in PLAY → phase advances by the old inc; the new inc is applied from the first strobe after LOOKUP.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI voice blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: voice state encoding, default accumulator width, MIDI field
// widths and the square-wave sample helper.
package midi_pkg;

  localparam int ACC_W_DEF = 24;  // default DDS accumulator / increment width
  localparam int NOTE_W    = 7;   // MIDI note number width
  localparam int VEL_W     = 7;   // MIDI velocity width
  localparam int WAVE_W    = 8;   // signed output sample width

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    PLAY    = 2'd2,
    RELEASE = 2'd3
  } voice_state_t;

  // Square sample: positive half when the phase MSB is clear. amp never
  // exceeds 127, so the negation cannot overflow the signed byte.
  function automatic logic signed [WAVE_W-1:0] square_sample(
    input logic             phase_msb,
    input logic [VEL_W-1:0] amp
  );
    logic signed [WAVE_W-1:0] mag;
    mag = $signed({1'b0, amp});
    return phase_msb ? -mag : mag;
  endfunction

endpackage

// File: rtl/midi_voice_env.sv
// Release envelope: velocity-loaded amplitude with a linear, divided decay.
// Latency: amp updates one clock after load/step; done is combinational.
// Backpressure: none; every load/start/step is taken in the cycle it is seen.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   load         note-on: amp <= load_amp, divider cleared (highest priority)
//   load_amp     velocity to load
//   start        entering release: divider cleared
//   step         one sample strobe while releasing
//   amp          current amplitude
//   done         high when this step leaves the amplitude at zero
module midi_voice_env
  import midi_pkg::*;
#(
  parameter int RELEASE_DIV = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [VEL_W-1:0] load_amp,
  input  logic             start,
  input  logic             step,
  output logic [VEL_W-1:0] amp,
  output logic             done
);

  // A divide-by-one still needs a 1-bit counter that simply stays at zero.
  localparam int CNT_W = (RELEASE_DIV > 1) ? $clog2(RELEASE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RELEASE_DIV - 1);

  logic [CNT_W-1:0] rel_cnt;
  logic             wrap;

  assign wrap = (rel_cnt == CNT_MAX);

  // Releasing ends either when amp is already zero or when the final
  // decrement from 1 happens on this strobe.
  assign done = step && ((amp == '0) || (wrap && (amp == VEL_W'(1))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      amp     <= '0;
      rel_cnt <= '0;
    end else if (load) begin
      amp     <= load_amp;
      rel_cnt <= '0;
    end else if (start) begin
      rel_cnt <= '0;
    end else if (step) begin
      if (wrap) begin
        rel_cnt <= '0;
        if (amp != '0) begin
          amp <= amp - 1'b1;
        end
      end else begin
        rel_cnt <= rel_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/midi_voice_dds.sv
// Monophonic MIDI voice: note events -> table lookup -> DDS square/saw with release.
// Latency: accepted note-on reaches PLAY 2 clocks later; o_wave registered on i_smp_en.
// Backpressure: o_ev_ready low only during the single LOOKUP cycle.
//
// Ports:
//   i_clk, i_res_n          clock, asynchronous active-low reset
//   i_smp_en                sample strobe; DDS and envelope advance only on it
//   i_ev_valid/o_ev_ready   event handshake; i_ev_on/i_ev_note/i_ev_vel payload
//   o_tbl_note/i_tbl_val    registered note out to the external increment
//                           table, combinational increment back
//   o_wave                  signed 8-bit sample
//   o_active                high while a note is sounding or being looked up
//
// Build option: define MIDI_VOICE_SAW_EN for a velocity-scaled sawtooth
// instead of the square wave (adds an 8x8 multiplier).
module midi_voice_dds
  import midi_pkg::*;
#(
  parameter int ACC_W       = ACC_W_DEF,
  parameter int RELEASE_DIV = 64
) (
  input  logic                     i_clk,
  input  logic                     i_res_n,
  input  logic                     i_smp_en,
  input  logic                     i_ev_valid,
  output logic                     o_ev_ready,
  input  logic                     i_ev_on,
  input  logic [NOTE_W-1:0]        i_ev_note,
  input  logic [VEL_W-1:0]         i_ev_vel,
  output logic [NOTE_W-1:0]        o_tbl_note,
  input  logic [ACC_W-1:0]         i_tbl_val,
  output logic signed [WAVE_W-1:0] o_wave,
  output logic                     o_active
);

  voice_state_t state;
  voice_state_t state_nxt;

  logic [ACC_W-1:0]         phase;
  logic [ACC_W-1:0]         inc;
  logic [NOTE_W-1:0]        cur_note;
  logic [VEL_W-1:0]         amp;
  logic                     env_done;

  logic                     ev_fire;
  logic                     ev_note_on;
  logic                     ev_note_off;
  logic                     rel_start;
  logic                     sounding;
  logic signed [WAVE_W-1:0] wave_nxt;

  // ---------------------------------------------------------------------
  // Event decode. A note-on with zero velocity is a note-off.
  // ---------------------------------------------------------------------
  assign o_ev_ready  = (state != LOOKUP);
  assign o_active    = (state != IDLE);
  assign ev_fire     = i_ev_valid && o_ev_ready;
  assign ev_note_on  = ev_fire && i_ev_on && (i_ev_vel != '0);
  assign ev_note_off = ev_fire && !ev_note_on;
  // Only the note currently playing can be released; everything else is
  // accepted and dropped.
  assign rel_start   = ev_note_off && (state == PLAY) && (i_ev_note == cur_note);
  assign sounding    = (state == PLAY) || (state == RELEASE);

  // ---------------------------------------------------------------------
  // Envelope
  // ---------------------------------------------------------------------
  midi_voice_env #(
    .RELEASE_DIV (RELEASE_DIV)
  ) u_env (
    .clk      (i_clk),
    .rst_n    (i_res_n),
    .load     (ev_note_on),
    .load_amp (i_ev_vel),
    .start    (rel_start),
    .step     (i_smp_en && (state == RELEASE)),
    .amp      (amp),
    .done     (env_done)
  );

  // ---------------------------------------------------------------------
  // FSM. Events take priority over the envelope finishing on the same
  // cycle, so a retrigger during the last release strobe still plays.
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ev_note_on) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        state_nxt = PLAY;
      end
      PLAY: begin
        if (ev_note_on)     state_nxt = LOOKUP;
        else if (rel_start) state_nxt = RELEASE;
      end
      RELEASE: begin
        if (ev_note_on)    state_nxt = LOOKUP;
        else if (env_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Sample generation from the pre-update phase and amplitude.
  // ---------------------------------------------------------------------
`ifdef MIDI_VOICE_SAW_EN
  logic signed [WAVE_W-1:0]   saw_top;
  logic signed [2*WAVE_W-1:0] saw_prod;

  assign saw_top  = $signed(phase[ACC_W-1 -: WAVE_W]);
  assign saw_prod = saw_top * $signed({1'b0, amp});
  // Scale back by 2^7 with an arithmetic shift; |result| <= 127 fits a byte.
  assign wave_nxt = WAVE_W'(saw_prod >>> 7);
`else
  assign wave_nxt = square_sample(phase[ACC_W-1], amp);
`endif

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      phase      <= '0;
      inc        <= '0;
      cur_note   <= '0;
      o_tbl_note <= '0;
      o_wave     <= '0;
    end else begin
      if (ev_note_on) begin
        cur_note   <= i_ev_note;
        o_tbl_note <= i_ev_note;
      end

      // The table answers combinationally for the note registered last cycle.
      if (state == LOOKUP) begin
        inc <= i_tbl_val;
      end

      // A fresh note starts at phase 0; a retrigger keeps the phase running
      // so there is no click. A strobe coinciding with a retrigger still
      // advances by the old increment.
      if (ev_note_on && (state == IDLE)) begin
        phase <= '0;
      end else if (i_smp_en && sounding) begin
        phase <= phase + inc;
      end

      // LOOKUP holds the last sample to avoid a gap between notes.
      if (i_smp_en) begin
        if (sounding) begin
          o_wave <= wave_nxt;
        end else if (state == IDLE) begin
          o_wave <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_voice_dds.sv
// Self-checking bench for midi_voice_dds: directed scenarios followed by a
// random segment, all compared against a behavioural voice model.
module tb_midi_voice_dds;

  localparam int RDIV = 4;

  localparam int M_IDLE = 0;
  localparam int M_LOOK = 1;
  localparam int M_PLAY = 2;
  localparam int M_REL  = 3;

  logic        i_clk;
  logic        i_res_n;
  logic        i_smp_en;
  logic        i_ev_valid;
  logic        o_ev_ready;
  logic        i_ev_on;
  logic [6:0]  i_ev_note;
  logic [6:0]  i_ev_vel;
  logic [6:0]  o_tbl_note;
  logic [23:0] i_tbl_val;
  logic signed [7:0] o_wave;
  logic        o_active;
  logic [7:0]  wave_u;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int          m_mode;
  int unsigned m_phase;
  int unsigned m_inc;
  int          m_note;
  int          m_amp;
  int          m_rel_n;
  int          m_wave;

  int unsigned ph_keep;
  logic [6:0]  notes [5] = '{7'd60, 7'd64, 7'd69, 7'd72, 7'd127};

  midi_voice_dds #(
    .ACC_W       (24),
    .RELEASE_DIV (RDIV)
  ) dut (
    .i_clk      (i_clk),
    .i_res_n    (i_res_n),
    .i_smp_en   (i_smp_en),
    .i_ev_valid (i_ev_valid),
    .o_ev_ready (o_ev_ready),
    .i_ev_on    (i_ev_on),
    .i_ev_note  (i_ev_note),
    .i_ev_vel   (i_ev_vel),
    .o_tbl_note (o_tbl_note),
    .i_tbl_val  (i_tbl_val),
    .o_wave     (o_wave),
    .o_active   (o_active)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Stand-in increment table: two real entries, a simple formula elsewhere.
  function automatic logic [23:0] tbl(input logic [6:0] n);
    case (n)
      7'd69:   return 24'h00CD0E;
      7'd127:  return 24'h16D5DC;
      default: return {17'b0, n} * 24'h0002F3 + 24'h000400;
    endcase
  endfunction

  assign i_tbl_val = tbl(o_tbl_note);
  assign wave_u    = o_wave;

  function automatic int wave_of(input int unsigned ph, input int amp);
`ifdef MIDI_VOICE_SAW_EN
    int t;
    t = int'(ph >> 16);
    if (t >= 128) t = t - 256;
    return (t * amp) >>> 7;
`else
    return (ph >= 32'h0080_0000) ? -amp : amp;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_phase = 0;
    m_inc   = 0;
    m_note  = 0;
    m_amp   = 0;
    m_rel_n = 0;
    m_wave  = 0;
  endtask

  // One clock of the voice, from the rules: the strobe works on the values
  // held before the clock, the event then decides the new note/state.
  task automatic model_step(input bit v, input bit on, input int note, input int vel, input bit smp);
    int          p_mode;
    int unsigned p_phase;
    int          p_amp;
    bit          fire, non, noff;
    p_mode  = m_mode;
    p_phase = m_phase;
    p_amp   = m_amp;
    fire    = v && (p_mode != M_LOOK);
    non     = fire && on && (vel != 0);
    noff    = fire && !non;

    if (smp) begin
      if (p_mode == M_PLAY || p_mode == M_REL) begin
        m_wave  = wave_of(p_phase, p_amp);
        m_phase = (p_phase + m_inc) % 32'h0100_0000;
      end else if (p_mode == M_IDLE) begin
        m_wave = 0;
      end
      if (p_mode == M_REL) begin
        if (p_amp == 0) begin
          m_mode = M_IDLE;
        end else begin
          m_rel_n++;
          if (m_rel_n % RDIV == 0) begin
            m_amp--;
            if (m_amp == 0) m_mode = M_IDLE;
          end
        end
      end
    end

    if (p_mode == M_LOOK) begin
      m_inc  = tbl(7'(m_note));
      m_mode = M_PLAY;
    end

    if (non) begin
      if (p_mode == M_IDLE) m_phase = 0;
      m_note  = note;
      m_amp   = vel;
      m_rel_n = 0;
      m_mode  = M_LOOK;
    end else if (noff && p_mode == M_PLAY && note == m_note) begin
      m_mode  = M_REL;
      m_rel_n = 0;
    end
  endtask

  task automatic check_all();
    chk("wave",     {24'b0, wave_u},     {24'b0, 8'(m_wave)});
    chk("active",   {31'b0, o_active},   {31'b0, m_mode != M_IDLE});
    chk("ready",    {31'b0, o_ev_ready}, {31'b0, m_mode != M_LOOK});
    chk("tbl_note", {25'b0, o_tbl_note}, 32'(m_note));
  endtask

  // One clock: drive, clock, advance the model, compare 1 ns after the edge.
  task automatic cyc(input bit v, input bit on, input logic [6:0] note,
                     input logic [6:0] vel, input bit smp);
    i_ev_valid = v;
    i_ev_on    = on;
    i_ev_note  = note;
    i_ev_vel   = vel;
    i_smp_en   = smp;
    @(posedge i_clk);
    model_step(v, on, int'(note), int'(vel), smp);
    #1;
    check_all();
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 7'd0, 7'd0, 1'b1);
  endtask

  initial begin
    i_res_n    = 1'b1;
    i_smp_en   = 1'b0;
    i_ev_valid = 1'b0;
    i_ev_on    = 1'b0;
    i_ev_note  = '0;
    i_ev_vel   = '0;
    model_reset();

    // reset state
    #1 i_res_n = 1'b0;
    #2;
    chk("rst_wave",     {24'b0, wave_u},     32'd0);
    chk("rst_active",   {31'b0, o_active},   32'd0);
    chk("rst_ready",    {31'b0, o_ev_ready}, 32'd1);
    chk("rst_tbl_note", {25'b0, o_tbl_note}, 32'd0);
    @(negedge i_clk) i_res_n = 1'b1;
    @(posedge i_clk);
    #1;

    // note-on 69 vel 127: one lookup cycle, then 160 strobes high
    cyc(1'b1, 1'b1, 7'd69, 7'd127, 1'b0);
    chk("lookup_tbl_note", {25'b0, o_tbl_note}, 32'd69);
    chk("lookup_ready",    {31'b0, o_ev_ready}, 32'd0);
    cyc(1'b0, 1'b0, 7'd0, 7'd0, 1'b0);
    chk("inc_69",     {8'b0, dut.inc},     32'h0000CD0E);
    chk("play_ready", {31'b0, o_ev_ready}, 32'd1);
    strobes(160);
    chk("sq_hi_160", {24'b0, wave_u}, 32'h7F);
    strobes(1);
    chk("sq_lo_161", {24'b0, wave_u}, 32'h81);
    strobes(20);

    // note-off for a note that is not playing
    cyc(1'b1, 1'b0, 7'd60, 7'd64, 1'b1);
    strobes(5);
    chk("wrong_off_active", {31'b0, o_active},   32'd1);
    chk("wrong_off_ready",  {31'b0, o_ev_ready}, 32'd1);

    // retrigger to note 127: fastest increment, phase wraps freely
    cyc(1'b1, 1'b1, 7'd127, 7'd100, 1'b0);
    cyc(1'b0, 1'b0, 7'd0, 7'd0, 1'b0);
    chk("inc_127", {8'b0, dut.inc}, 32'h0016D5DC);
    for (int i = 0; i < 60; i++) begin
      strobes(1);
      chk("phase_wrap", {8'b0, dut.phase}, m_phase);
    end

    // release of a vel-2 note with a divide-by-4 decay
    cyc(1'b1, 1'b1, 7'd69, 7'd2, 1'b0);
    cyc(1'b0, 1'b0, 7'd0, 7'd0, 1'b0);
    strobes(3);
    cyc(1'b1, 1'b0, 7'd69, 7'd0, 1'b0);
    strobes(4);
    chk("rel_amp_4",    {25'b0, dut.u_env.amp}, 32'd1);
    chk("rel_active_4", {31'b0, o_active},      32'd1);
    strobes(3);
    chk("rel_active_7", {31'b0, o_active},      32'd1);
    strobes(1);
    chk("rel_amp_8",    {25'b0, dut.u_env.amp}, 32'd0);
    chk("rel_idle_8",   {31'b0, o_active},      32'd0);
    strobes(1);
    chk("idle_wave", {24'b0, wave_u}, 32'd0);

    // velocity-0 note-on releases; a new note-on during release keeps phase
    cyc(1'b1, 1'b1, 7'd72, 7'd100, 1'b0);
    cyc(1'b0, 1'b0, 7'd0, 7'd0, 1'b0);
    strobes(7);
    cyc(1'b1, 1'b1, 7'd72, 7'd0, 1'b0);
    strobes(3);
    chk("vel0_active", {31'b0, o_active},      32'd1);
    chk("vel0_amp",    {25'b0, dut.u_env.amp}, 32'd100);
    ph_keep = m_phase;
    cyc(1'b1, 1'b1, 7'd64, 7'd50, 1'b0);
    chk("retrig_ready", {31'b0, o_ev_ready},    32'd0);
    chk("retrig_phase", {8'b0, dut.phase},      ph_keep);
    chk("retrig_amp",   {25'b0, dut.u_env.amp}, 32'd50);
    cyc(1'b0, 1'b0, 7'd0, 7'd0, 1'b0);
    strobes(5);

    // event coincident with a strobe: old increment used for that strobe
    ph_keep = m_phase;
    cyc(1'b1, 1'b1, 7'd69, 7'd90, 1'b1);
    ph_keep = (ph_keep + tbl(7'd64)) % 32'h0100_0000;
    chk("coinc_phase", {8'b0, dut.phase}, ph_keep);
    cyc(1'b0, 1'b0, 7'd0, 7'd0, 1'b1);
    chk("coinc_lookup_hold", {8'b0, dut.phase}, ph_keep);
    strobes(1);
    chk("coinc_new_inc", {8'b0, dut.phase}, (ph_keep + 32'h0000CD0E) % 32'h0100_0000);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic       v, on, smp;
      logic [6:0] n, vel;
      v   = ($urandom_range(0, 9) == 0);
      on  = ($urandom_range(0, 2) != 0);
      n   = notes[$urandom_range(0, 4)];
      vel = ($urandom_range(0, 4) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      smp = 1'($urandom_range(0, 1));
      cyc(v, on, n, vel, smp);
    end

    // asynchronous reset in the middle of a note
    cyc(1'b1, 1'b1, 7'd69, 7'd127, 1'b0);
    cyc(1'b0, 1'b0, 7'd0, 7'd0, 1'b0);
    strobes(10);
    i_smp_en   = 1'b0;
    i_ev_valid = 1'b0;
    #2 i_res_n = 1'b0;
    #1;
    chk("arst_wave",     {24'b0, wave_u},     32'd0);
    chk("arst_active",   {31'b0, o_active},   32'd0);
    chk("arst_ready",    {31'b0, o_ev_ready}, 32'd1);
    chk("arst_tbl_note", {25'b0, o_tbl_note}, 32'd0);
    chk("arst_phase",    {8'b0, dut.phase},   32'd0);
    model_reset();
    @(negedge i_clk) i_res_n = 1'b1;
    @(posedge i_clk);
    #1;
    strobes(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
